// File: rtl/cmlink_pkg.sv
// Shared types and constants for the Camera Link to AXI4-Stream video bridge.
package cmlink_pkg;
  localparam int PIX_W   = 24;
  localparam int ENTRY_W = PIX_W + 2;
  localparam int E_LAST  = PIX_W;
  localparam int E_SOF   = PIX_W + 1;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_ARMED     = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_DROP      = 2'd3
  } state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic sof, input logic last,
                                                     input logic [PIX_W-1:0] pix);
    return {sof, last, pix};
  endfunction
endpackage

// File: rtl/cmlink_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is presented combinationally from the array.
module cmlink_sync_fifo #(
  parameter int AW = 10,
  parameter int W  = 26
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wr_ptr_reg, rd_ptr_reg;
  logic         do_rd, do_wr;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted then.
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/cmlink_dcp2axis.sv
// Camera Link base-mode pixels to AXI4-Stream video with frame measurement and overflow-driven frame drop.
module cmlink_dcp2axis
  import cmlink_pkg::*;
#(
  parameter int FIFO_AW = 10,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_fvld,
  input  logic               i_lvld,
  input  logic               i_dvld,
  input  logic [7:0]         i_porta,
  input  logic [7:0]         i_portb,
  input  logic [7:0]         i_portc,
  input  logic               i_en,
  output logic [PIX_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic [CNT_W-1:0]   o_width,
  output logic [CNT_W-1:0]   o_height,
  output logic               o_meas_vld,
  output logic               o_ovf,
  output logic [FIFO_AW:0]   o_fifo_lvl
);
  state_t             state_reg, state_next;
  logic               fvld_d_reg, lvld_d_reg;
  logic               sof_pend_reg, sof_pend_next;
  logic               hold_vld_reg, hold_vld_next, hold_sof_reg, hold_sof_next;
  logic [PIX_W-1:0]   hold_pix_reg, hold_pix_next, pix;
  logic [CNT_W-1:0]   pix_cnt_reg, pix_cnt_next, line_cnt_reg, line_cnt_next;
  logic [CNT_W-1:0]   last_w_reg, last_w_next, width_reg, height_reg;
  logic               meas_vld_reg, ovf_reg;
  logic               strobe, fvld_rise, fvld_fall, lvld_rise, line_end;
  logic               frame_start, capture, push, pop, meas_upd, ovf_set;
  logic [ENTRY_W-1:0] push_entry, head;
  logic               fifo_full, fifo_empty;
  logic [7:0]         port_arr [3];

  assign port_arr[0] = i_porta;
  assign port_arr[1] = i_portb;
  assign port_arr[2] = i_portc;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pix
      assign pix[gi*8 +: 8] = port_arr[gi];
    end
  endgenerate

  assign strobe      = i_fvld & i_lvld & i_dvld;
  assign fvld_rise   = i_fvld & ~fvld_d_reg;
  assign fvld_fall   = ~i_fvld & fvld_d_reg;
  assign lvld_rise   = i_lvld & ~lvld_d_reg;
  // A line also ends if fvld drops while lvld is still high.
  assign line_end    = lvld_d_reg & (~i_lvld | ~i_fvld);
  assign frame_start = (state_reg == ST_ARMED) & fvld_rise & i_en;
  assign capture     = (state_reg == ST_ACTIVE) | frame_start;
  assign pop         = m_axis_tvalid & m_axis_tready;

  always_comb begin
    sof_pend_next = sof_pend_reg;
    hold_vld_next = hold_vld_reg;
    hold_sof_next = hold_sof_reg;
    hold_pix_next = hold_pix_reg;
    pix_cnt_next  = pix_cnt_reg;
    line_cnt_next = line_cnt_reg;
    last_w_next   = last_w_reg;
    push          = 1'b0;
    push_entry    = pack_entry(hold_sof_reg, 1'b0, hold_pix_reg);
    meas_upd      = 1'b0;
    ovf_set       = 1'b0;
    if (capture) begin
      if (frame_start) begin
        sof_pend_next = 1'b1;
        pix_cnt_next  = '0;
        line_cnt_next = '0;
        last_w_next   = '0;
      end
      if (lvld_rise) pix_cnt_next = '0;
      if (strobe) begin
        push          = hold_vld_reg;
        hold_vld_next = 1'b1;
        hold_sof_next = sof_pend_next;
        hold_pix_next = pix;
        sof_pend_next = 1'b0;
        if (pix_cnt_next != '1) pix_cnt_next = pix_cnt_next + 1'b1;
      end else if ((line_end || fvld_fall) && hold_vld_reg) begin
        push          = 1'b1;
        push_entry    = pack_entry(hold_sof_reg, 1'b1, hold_pix_reg);
        hold_vld_next = 1'b0;
      end
      if (line_end && !frame_start && pix_cnt_reg != '0) begin
        if (line_cnt_reg != '1) line_cnt_next = line_cnt_reg + 1'b1;
        last_w_next = pix_cnt_reg;
      end
      if (fvld_fall) meas_upd = 1'b1;
      if (push && fifo_full && !pop) begin
        ovf_set  = 1'b1;
        meas_upd = 1'b0;
      end
    end else begin
      hold_vld_next = 1'b0;
      sof_pend_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT_IDLE: if (!i_fvld) state_next = ST_ARMED;
      ST_ARMED:     if (frame_start) state_next = ST_ACTIVE;
      ST_ACTIVE: begin
        if (fvld_fall)    state_next = i_en ? ST_ARMED : ST_WAIT_IDLE;
        else if (ovf_set) state_next = ST_DROP;
      end
      ST_DROP:      if (fvld_fall) state_next = i_en ? ST_ARMED : ST_WAIT_IDLE;
      default:      state_next = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg    <= ST_WAIT_IDLE;
      fvld_d_reg   <= 1'b0;
      lvld_d_reg   <= 1'b0;
      sof_pend_reg <= 1'b0;
      hold_vld_reg <= 1'b0;
      hold_sof_reg <= 1'b0;
      hold_pix_reg <= '0;
      pix_cnt_reg  <= '0;
      line_cnt_reg <= '0;
      last_w_reg   <= '0;
      width_reg    <= '0;
      height_reg   <= '0;
      meas_vld_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fvld_d_reg   <= i_fvld;
      lvld_d_reg   <= i_lvld;
      sof_pend_reg <= sof_pend_next;
      hold_vld_reg <= hold_vld_next;
      hold_sof_reg <= hold_sof_next;
      hold_pix_reg <= hold_pix_next;
      pix_cnt_reg  <= pix_cnt_next;
      line_cnt_reg <= line_cnt_next;
      last_w_reg   <= last_w_next;
      meas_vld_reg <= meas_upd;
      if (meas_upd) begin
        width_reg  <= last_w_next;
        height_reg <= line_cnt_next;
      end
      if (frame_start)  ovf_reg <= 1'b0;
      else if (ovf_set) ovf_reg <= 1'b1;
    end
  end

  cmlink_sync_fifo #(.AW(FIFO_AW), .W(ENTRY_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (m_axis_tready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_fifo_lvl)
  );

  // Beat fields are masked while empty so nothing stale from the array shows up.
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : head[PIX_W-1:0];
  assign m_axis_tuser  = ~fifo_empty & head[E_SOF];
  assign m_axis_tlast  = ~fifo_empty & head[E_LAST];
  assign o_width       = width_reg;
  assign o_height      = height_reg;
  assign o_meas_vld    = meas_vld_reg;
  assign o_ovf         = ovf_reg;
endmodule

// File: tb/tb_cmlink_dcp2axis.sv
// Self-checking bench for cmlink_dcp2axis: frame table plus overflow and reset corner sequences.
module tb_cmlink_dcp2axis;
  localparam int AW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fvld, lvld, dvld, en;
  logic [7:0]    pa, pb, pc;
  logic [23:0]   tdata;
  logic          tvalid, tready, tuser, tlast;
  logic [CW-1:0] width, height;
  logic          meas_vld, ovf;
  logic [AW:0]   lvl;

  cmlink_dcp2axis #(.FIFO_AW(AW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_fvld(fvld), .i_lvld(lvld), .i_dvld(dvld),
    .i_porta(pa), .i_portb(pb), .i_portc(pc), .i_en(en),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .o_width(width), .o_height(height), .o_meas_vld(meas_vld), .o_ovf(ovf),
    .o_fifo_lvl(lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; bit toggle; bit en; int rdy; bit zline;
    int exp_w; int exp_h; bit exp_meas;
  } vec_t;

  vec_t         vecs [7];
  logic [25:0]  sb [$];
  int           n_vec = 0, n_err = 0;
  int           meas_cnt = 0, beat_no = 0;
  int           ready_mode = 1;
  int           ref_w = 0, ref_h = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tready driver: 0 = held low, 1 = held high, 2 = random 50%
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode != 0);
    end
  end

  // Output monitor: scoreboard pop on transfer, hold-stable check while stalled
  initial begin
    logic        stalled;
    logic [25:0] prev, got;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        got = {tuser, tlast, tdata};
        if (stalled) check("stall_hold", {37'd0, tvalid, got}, {37'd0, 1'b1, prev});
        if (meas_vld) meas_cnt++;
        if (tvalid && tready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 64'(got), 64'h3ffffff);
          end else begin
            check("beat", 64'(got), 64'(sb[0]));
            $display("beat %0d: tdata=%06h tuser=%0b tlast=%0b", beat_no, tdata, tuser, tlast);
            void'(sb.pop_front());
            beat_no++;
          end
        end
        stalled = tvalid && !tready;
        prev = got;
      end
    end
  end

  task automatic run_frame(input vec_t v, input int fid, input bit throttle, input int cap);
    int pushed;
    pushed = 0;
    en = v.en;
    fvld = 1'b1;
    tick();
    for (int l = 0; l < v.h; l++) begin
      lvld = 1'b1;
      for (int p = 0; p < v.w; p++) begin
        if (v.toggle) begin
          dvld = 1'b0;
          tick();
        end
        if (throttle) begin
          int guard;
          guard = 0;
          dvld = 1'b0;
          while (int'(lvl) >= 6 && guard < 300) begin
            tick();
            guard++;
          end
          if (guard >= 300) check("throttle_timeout", 64'(guard), 64'd0);
        end
        dvld = 1'b1;
        pa = 8'(p); pb = 8'(l); pc = 8'(fid);
        if (v.en && pushed < cap) begin
          sb.push_back({1'(l == 0 && p == 0), 1'(p == v.w - 1), pc, pb, pa});
          pushed++;
        end
        tick();
      end
      dvld = 1'b0;
      lvld = 1'b0;
      repeat (3) tick();
      if (v.zline && l == 0) begin
        lvld = 1'b1;
        repeat (3) tick();
        lvld = 1'b0;
        repeat (2) tick();
      end
    end
    fvld = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || tvalid) && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int fid);
    int m0;
    m0 = meas_cnt;
    ready_mode = v.rdy;
    run_frame(v, fid, 1'b1, 1000);
    drain();
    ready_mode = 1;
    tick();
    if (v.exp_meas) begin
      ref_w = v.exp_w;
      ref_h = v.exp_h;
    end
    check("meas_pulses", 64'(meas_cnt - m0), 64'(v.exp_meas ? 1 : 0));
    check("width", 64'(width), 64'(ref_w));
    check("height", 64'(height), 64'(ref_h));
    check("ovf_clear", 64'(ovf), 64'd0);
    check("lvl_empty", 64'(lvl), 64'd0);
  endtask

  initial begin
    vec_t ov;
    int   m0;
    vecs[0] = '{4, 3, 1'b0, 1'b1, 1, 1'b0, 4, 3, 1'b1};
    vecs[1] = '{4, 3, 1'b1, 1'b1, 1, 1'b0, 4, 3, 1'b1};
    vecs[2] = '{4, 3, 1'b0, 1'b1, 2, 1'b0, 4, 3, 1'b1};
    vecs[3] = '{5, 2, 1'b1, 1'b1, 2, 1'b1, 5, 2, 1'b1};
    vecs[4] = '{3, 2, 1'b0, 1'b0, 1, 1'b0, 0, 0, 1'b0};
    vecs[5] = '{1, 1, 1'b0, 1'b1, 1, 1'b0, 1, 1, 1'b1};
    vecs[6] = '{6, 4, 1'b1, 1'b1, 2, 1'b0, 6, 4, 1'b1};

    rst_n = 1'b0; fvld = 1'b0; lvld = 1'b0; dvld = 1'b0; en = 1'b1;
    pa = '0; pb = '0; pc = '0;
    repeat (3) tick();
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_beat", 64'({tuser, tlast, tdata}), 64'd0);
    check("rst_lvl", 64'(lvl), 64'd0);
    check("rst_meas", 64'({meas_vld, ovf, width, height}), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], i + 1);

    // Overflow: depth-8 FIFO, no drain, one 16-pixel line
    m0 = meas_cnt;
    ready_mode = 0;
    tick();
    ov = '{16, 1, 1'b0, 1'b1, 0, 1'b0, 0, 0, 1'b0};
    run_frame(ov, 8'h20, 1'b0, 8);
    check("ovf_set", 64'(ovf), 64'd1);
    check("ovf_lvl", 64'(lvl), 64'd8);
    check("ovf_no_meas", 64'(meas_cnt - m0), 64'd0);
    ready_mode = 1;
    drain();
    check("ovf_sticky", 64'(ovf), 64'd1);
    apply_vec(vecs[0], 8'h21);

    // Async reset mid-line with FIFO occupied, released while fvld is still high
    ready_mode = 0;
    m0 = meas_cnt;
    en = 1'b1;
    fvld = 1'b1;
    tick();
    lvld = 1'b1;
    dvld = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pa = 8'(p); pb = 8'h0; pc = 8'h30;
      tick();
    end
    check("pre_rst_lvl", 64'(lvl), 64'd4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_tvalid", 64'(tvalid), 64'd0);
    check("async_lvl", 64'(lvl), 64'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pa = 8'(p + 8); pc = 8'h31;
      tick();
    end
    dvld = 1'b0;
    lvld = 1'b0;
    repeat (2) tick();
    fvld = 1'b0;
    ready_mode = 1;
    repeat (20) tick();
    check("midframe_ignored", 64'({tvalid, lvl}), 64'd0);
    check("midframe_no_meas", 64'(meas_cnt - m0), 64'd0);
    ref_w = 0;
    ref_h = 0;
    apply_vec(vecs[0], 8'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
